// File: rtl/serial_logical_eq_pkg.sv
// Shared types and helpers for the bit-serial logical-equality comparator.
package serial_logical_eq_pkg;

    typedef enum logic {ACCUM, RESULT} state_t;

    // Width needed to hold a beat count in the range 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_logical_eq_if.sv
// Beat-in / result-out stream bundle for serial_logical_eq.
interface serial_logical_eq_if #(
    parameter int N = 8
);
    localparam int CW = serial_logical_eq_pkg::cnt_width(N);

    logic          in_valid;
    logic          in_ready;
    logic          in_a;
    logic          in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_eq;
    logic          out_ne;
    logic [CW-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_eq, out_ne, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_eq, out_ne, out_count
    );

endinterface

// File: rtl/serial_logical_eq_or_acc.sv
// Sticky 1-bit OR accumulator: once a 1 is seen it holds until cleared.
module serial_or_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (en)  q <= q | d;
    end

endmodule

// File: rtl/serial_logical_eq.sv
// Bit-serial logical equality: OR-accumulates A and B truthiness over up to
// N beats, then holds a registered EQ/NE result until it is consumed.
module serial_logical_eq
    import serial_logical_eq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    serial_logical_eq_if.slave bus
);

    localparam int CW = cnt_width(N);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          acc_a, acc_b;
    logic          acc_clr, acc_en;
    logic          eq_r, ne_r;
    logic [CW-1:0] cnt_r;
    logic          fin_a, fin_b;

    assign count_nxt = count + CW'(1);

    // Accumulators follow the FSM: load only on accepted beats, wipe on
    // abort or once the result has been handed off.
    assign acc_en  = bus.in_valid & (state == ACCUM) & ~clear;
    assign acc_clr = clear | ((state == RESULT) & bus.out_ready);

    // Folding the current beat in lets the result register on the final beat.
    assign fin_a = acc_a | bus.in_a;
    assign fin_b = acc_b | bus.in_b;

    serial_or_acc u_acc_a (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .en   (acc_en),
        .d    (bus.in_a),
        .q    (acc_a)
    );

    serial_or_acc u_acc_b (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr),
        .en   (acc_en),
        .d    (bus.in_b),
        .q    (acc_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            count <= '0;
            eq_r  <= 1'b1;
            ne_r  <= 1'b0;
            cnt_r <= '0;
        end else if (clear) begin
            state <= ACCUM;
            count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        count <= count_nxt;
                        if (bus.in_last || count_nxt == CW'(N)) begin
                            state <= RESULT;
                            eq_r  <= ~(fin_a ^ fin_b);
                            ne_r  <= fin_a ^ fin_b;
                            cnt_r <= count_nxt;
                        end
                    end
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        state <= ACCUM;
                        count <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == RESULT);
    assign bus.out_eq    = eq_r;
    assign bus.out_ne    = ne_r;
    assign bus.out_count = cnt_r;

endmodule

// File: tb/tb_serial_logical_eq.sv
// Directed self-checking bench for serial_logical_eq with N=8.
module tb_serial_logical_eq;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    serial_logical_eq_if #(.N(N)) bus ();

    serial_logical_eq #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Drives nb beats starting from posedge+1; returns at posedge+1 after the last beat.
    task automatic stream(input logic [7:0] a, input logic [7:0] b, input int nb, input bit use_last);
        for (int i = 0; i < nb; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = a[i];
            bus.in_b     = b[i];
            bus.in_last  = use_last && (i == nb - 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_eq !== 1'b1 || bus.out_ne !== 1'b0) begin errors++; $display("FAIL reset_eq_ne got %b/%b exp 1/0", bus.out_eq, bus.out_ne); end
        checks++; if (bus.out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.out_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero;
        bus.out_ready = 1'b1;
        stream(8'h00, 8'h00, 8, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_eq !== 1'b1 || bus.out_ne !== 1'b0) begin errors++; $display("FAIL zero_eq_ne got %b/%b exp 1/0", bus.out_eq, bus.out_ne); end
        checks++; if (bus.out_count !== 4'd8) begin errors++; $display("FAIL zero_count got %0d exp 8", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_bubble_ready got %b exp 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_consumed got valid %b ready %b exp 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_values;
        stream(8'h80, 8'h01, 8, 1'b0);
        checks++; if (bus.out_eq !== 1'b1 || bus.out_ne !== 1'b0 || bus.out_count !== 4'd8) begin errors++; $display("FAIL both_nonzero got eq %b ne %b cnt %0d exp 1 0 8", bus.out_eq, bus.out_ne, bus.out_count); end
        @(posedge clk); #1;
        stream(8'h40, 8'h00, 8, 1'b0);
        checks++; if (bus.out_eq !== 1'b0 || bus.out_ne !== 1'b1 || bus.out_count !== 4'd8) begin errors++; $display("FAIL a_only got eq %b ne %b cnt %0d exp 0 1 8", bus.out_eq, bus.out_ne, bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_early_last;
        stream(8'b101, 8'b000, 3, 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL early_hs got valid %b ready %b exp 1 0", bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_eq !== 1'b0 || bus.out_count !== 4'd3) begin errors++; $display("FAIL early_result got eq %b cnt %0d exp 0 3", bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        stream(8'h01, 8'h01, 8, 1'b0);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 1'b1;
            bus.in_b     = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_eq !== 1'b1 || bus.out_count !== 4'd8) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got valid %b ready %b eq %b cnt %0d exp 1 0 1 8", c, bus.out_valid, bus.in_ready, bus.out_eq, bus.out_count);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.out_valid); end
        // Held beats must not have leaked into the next comparison.
        stream(8'h00, 8'h02, 2, 1'b1);
        checks++; if (bus.out_eq !== 1'b0 || bus.out_count !== 4'd2) begin errors++; $display("FAIL bp_next got eq %b cnt %0d exp 0 2", bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        bus.out_ready = 1'b1;
        stream(8'h0F, 8'h00, 4, 1'b0);
        clear = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0; bus.in_last = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_accum got valid %b ready %b exp 0 1", bus.out_valid, bus.in_ready); end
        stream(8'h00, 8'h00, 8, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_eq !== 1'b1 || bus.out_count !== 4'd8) begin errors++; $display("FAIL clr_fresh got valid %b eq %b cnt %0d exp 1 1 8", bus.out_valid, bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        stream(8'hFF, 8'h00, 8, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_eq !== 1'b0) begin errors++; $display("FAIL clr_pending got valid %b eq %b exp 1 0", bus.out_valid, bus.out_eq); end
        clear = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_result got valid %b ready %b exp 0 1", bus.out_valid, bus.in_ready); end
        // Accumulators must be empty after clearing a pending result.
        stream(8'h00, 8'h00, 1, 1'b1);
        checks++; if (bus.out_eq !== 1'b1 || bus.out_count !== 4'd1) begin errors++; $display("FAIL clr_after got eq %b cnt %0d exp 1 1", bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b1;
        stream(8'h01, 8'h00, 1, 1'b1);
        checks++; if (bus.out_eq !== 1'b0 || bus.out_count !== 4'd1) begin errors++; $display("FAIL rm_pre got eq %b cnt %0d exp 0 1", bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
        stream(8'hFF, 8'h00, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_hs got ready %b valid %b exp 1 0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.out_eq !== 1'b1 || bus.out_ne !== 1'b0 || bus.out_count !== 4'd0) begin errors++; $display("FAIL rm_outs got eq %b ne %b cnt %0d exp 1 0 0", bus.out_eq, bus.out_ne, bus.out_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stream(8'h10, 8'h20, 8, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_eq !== 1'b1 || bus.out_count !== 4'd8) begin errors++; $display("FAIL rm_fresh got valid %b eq %b cnt %0d exp 1 1 8", bus.out_valid, bus.out_eq, bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_last_on_nth;
        stream(8'h00, 8'h80, 8, 1'b1);
        checks++; if (bus.out_eq !== 1'b0 || bus.out_ne !== 1'b1 || bus.out_count !== 4'd8) begin errors++; $display("FAIL last_nth got eq %b ne %b cnt %0d exp 0 1 8", bus.out_eq, bus.out_ne, bus.out_count); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL last_nth_done got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 1'b0;
        bus.in_b      = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_zero();
        test_values();
        test_early_last();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_last_on_nth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
